// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-FF input synchroniser, mid-bit sampling, one-deep
// output register with valid/ack handshake, framing and overrun flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 sourceClk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_ovr;

    logic                 w_rx_s;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_load;
    logic                 w_ferr;

    assign w_rx_s = r_sync2;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge sourceClk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge sourceClk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_ONE;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rx_s;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + IDX_ONE;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sourceClk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // An ack coinciding with a load consumes the old byte, so no overrun.
    always_ff @(posedge sourceClk or posedge reset) begin
        if (reset) begin
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            if (w_load) begin
                r_byte  <= r_shift;
                r_valid <= 1'b1;
                if (r_valid && !rx_ack) begin
                    r_ovr <= 1'b1;
                end else if (r_valid) begin
                    r_ovr <= 1'b0;
                end
            end else if (r_valid && rx_ack) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign rx_byte     = r_byte;
    assign rx_valid    = r_valid;
    assign frame_error = r_ferr;
    assign overrun     = r_ovr;
    assign rx_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven as serial waveforms, the
// expected event is queued at send time and a monitor checks each DUT event.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int LAT_MIN = 152;
    localparam int LAT_MAX = 156;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       rx_ack;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .sourceClk  (clk),
        .reset      (rst),
        .rx_in      (rx_in),
        .rx_ack     (rx_ack),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .frame_error(frame_error),
        .overrun    (overrun),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int unsigned t0;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          auto_ack = 0;
    int unsigned last_lat = 155;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic hold(logic v, int n);
        rx_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [7:0] d, logic stop, bit push);
        ev_t e;
        if (push) begin
            e.is_err = !stop;
            e.data   = d;
            e.t0     = cyc;
            exp_q.push_back(e);
        end
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(stop, CPB);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic drain_valid();
        int n = 0;
        while (rx_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("valid_drained", rx_valid, 1'b0);
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_byte"}, rx_byte, 8'h00);
        chk({tag, "_valid"}, rx_valid, 1'b0);
        chk({tag, "_ferr"}, frame_error, 1'b0);
        chk({tag, "_ovr"}, overrun, 1'b0);
        chk({tag, "_busy"}, rx_busy, 1'b0);
    endtask

    task automatic handle(bit is_err);
        ev_t e;
        int  lat;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got err=%0d byte=%0h expected none", is_err, rx_byte);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", is_err, e.is_err);
        lat = int'(cyc - e.t0);
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
        if (!is_err) begin
            chk("rx_byte", rx_byte, e.data);
            chk("no_overrun", overrun, 1'b0);
            last_lat = lat;
        end
    endtask

    // Monitor: a rising rx_valid is a load, each high frame_error cycle an error event.
    initial begin
        logic prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rx_valid && !prev_v) handle(1'b0);
                if (frame_error) handle(1'b1);
            end
            prev_v = rx_valid;
        end
    end

    // Consumer: random acks, including ones that arrive while nothing is valid.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack) rx_ack = ($urandom_range(0, 1) == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        int unsigned t0;
        int          k;

        rst    = 1'b1;
        rx_in  = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        hold(1'b1, 5);

        // Loopback-style single frame
        auto_ack = 1;
        send(8'hA9, 1'b1, 1);
        hold(1'b1, 10);
        drain_valid();

        // Short low glitch must be rejected silently
        auto_ack = 0;
        rx_ack   = 1'b0;
        hold(1'b0, 4);
        hold(1'b1, 4);
        chk("glitch_busy", rx_busy, 1'b1);
        hold(1'b1, 30);
        chk("glitch_valid", rx_valid, 1'b0);
        chk("glitch_busy_end", rx_busy, 1'b0);
        chk("glitch_ovr", overrun, 1'b0);

        // Framing error, line then held low as a break
        send(8'h55, 1'b0, 1);
        hold(1'b0, 20);
        chk("break_busy", rx_busy, 1'b1);
        chk("break_valid", rx_valid, 1'b0);
        hold(1'b1, 6);
        chk("break_busy_end", rx_busy, 1'b0);

        // Overrun: two bytes, no ack
        send(8'h12, 1'b1, 1);
        send(8'h34, 1'b1, 0);
        hold(1'b1, 4);
        chk("ovr_byte", rx_byte, 8'h34);
        chk("ovr_valid", rx_valid, 1'b1);
        chk("ovr_flag", overrun, 1'b1);
        ack_pulse();
        chk("ovr_ack_valid", rx_valid, 1'b0);
        chk("ovr_ack_flag", overrun, 1'b0);
        hold(1'b1, 4);

        // Ack colliding with the second load
        send(8'h5A, 1'b1, 1);
        t0 = cyc;
        fork
            send(8'hA5, 1'b1, 0);
            begin
                repeat (last_lat - 1) @(posedge clk);
                #1;
                ack_pulse();
            end
        join
        hold(1'b1, 3);
        chk("coll_valid", rx_valid, 1'b1);
        chk("coll_byte", rx_byte, 8'hA5);
        chk("coll_ovr", overrun, 1'b0);
        ack_pulse();
        chk("coll_ack_valid", rx_valid, 1'b0);
        hold(1'b1, 4);

        // Reset in the middle of data bit 3, with a byte still pending
        send(8'h77, 1'b1, 1);
        hold(1'b1, 4);
        chk("pre_rst_valid", rx_valid, 1'b1);
        hold(1'b0, CPB);
        d = 8'hFF;
        for (int i = 0; i < 3; i++) hold(d[i], CPB);
        hold(1'b0, CPB / 2);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outs("midrst");
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        hold(1'b1, 5);
        auto_ack = 1;
        send(8'hC3, 1'b1, 1);
        hold(1'b1, 10);

        // Randomised traffic: good, bad-stop and glitch frames, variable gaps
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 7);
            d = 8'($urandom);
            if (k == 0) begin
                hold(1'b0, $urandom_range(1, 6));
                hold(1'b1, 24);
            end else if (k == 1) begin
                send(d, 1'b0, 1);
                hold(1'b0, $urandom_range(0, 8));
                hold(1'b1, $urandom_range(4, 10));
            end else begin
                send(d, 1'b1, 1);
                hold(1'b1, $urandom_range(0, 10));
            end
        end
        hold(1'b1, 10);

        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got none expected err=%0d byte=%0h", e.is_err, e.data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
